// File: rtl/d_cache_wb_assoc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | d_cache_wb_assoc: 2-way set-associative write-back/write-allocate dcache |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module d_cache_wb_assoc #(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4,
    parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int WORD_BITS  = OFFSET_WIDTH - 2;
    localparam int LINE_WORDS = 1 << WORD_BITS;
    localparam int IDX_W      = INDEX_WIDTH + WORD_BITS;
    localparam logic [WORD_BITS-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_RF = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [WORD_BITS-1:0]     cnt_q, cnt_d;
    logic                     mreq_q, mreq_d, mwait_q, mwait_d;
    logic [TAG_WIDTH-1:0]     tag_save_q, tag_save_d;
    logic [INDEX_WIDTH-1:0]   index_save_q, index_save_d;
    logic                     victim_q, victim_d;
    logic [1:0][SETS-1:0]     valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0]          lru_q, lru_d;

    logic [TAG_WIDTH-1:0]     tag_mem  [2][SETS];
    logic [31:0]              data_mem [2][SETS*LINE_WORDS];

    logic [TAG_WIDTH-1:0]     req_tag;
    logic [INDEX_WIDTH-1:0]   req_index;
    logic [WORD_BITS-1:0]     req_word;
    logic [1:0]               hit_w;
    logic                     hit, hit_way, victim_sel, ack, mem_done;
    logic [3:0]               be;
    logic                     tag_we, data_we, data_way;
    logic [IDX_W-1:0]         data_idx;
    logic [3:0]               data_be;
    logic [31:0]              data_wdata;

    assign req_tag   = cpu_data_addr[31 -: TAG_WIDTH];
    assign req_index = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_word  = cpu_data_addr[2 +: WORD_BITS];

    assign hit_w[0]  = valid_q[0][req_index] && (tag_mem[0][req_index] == req_tag);
    assign hit_w[1]  = valid_q[1][req_index] && (tag_mem[1][req_index] == req_tag);
    assign hit       = |hit_w;
    assign hit_way   = hit_w[1];

    // Fill an invalid way first; only fall back to LRU when the set is full.
    assign victim_sel = !valid_q[0][req_index] ? 1'b0 :
                        !valid_q[1][req_index] ? 1'b1 : lru_q[req_index];

    // A beat completes on data_ok, including data_ok coincident with addr_ok.
    assign mem_done = (mreq_q && cache_data_addr_ok && cache_data_data_ok) ||
                      (mwait_q && cache_data_data_ok);

    always_comb begin
        be = 4'b1111;
        case (cpu_data_size)
            2'd0:    be = 4'b0001 << cpu_data_addr[1:0];
            2'd1:    be = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mreq_d       = mreq_q;
        mwait_d      = mwait_q;
        tag_save_d   = tag_save_q;
        index_save_d = index_save_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lru_d        = lru_q;
        ack          = 1'b0;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        data_way     = hit_way;
        data_idx     = {req_index, req_word};
        data_be      = be;
        data_wdata   = cpu_data_wdata;
        case (state_q)
            S_IDLE: begin
                if (cpu_data_req) begin
                    if (hit) begin
                        ack               = 1'b1;
                        lru_d[req_index]  = ~hit_way;
                        if (cpu_data_wr) begin
                            data_we                     = 1'b1;
                            dirty_d[hit_way][req_index] = 1'b1;
                        end
                    end else begin
                        tag_save_d   = req_tag;
                        index_save_d = req_index;
                        victim_d     = victim_sel;
                        state_d      = (valid_q[victim_sel][req_index] && dirty_q[victim_sel][req_index])
                                       ? S_WB : S_RF;
                    end
                end
            end
            S_WB, S_RF: begin
                if (!mreq_q && !mwait_q) begin
                    mreq_d = 1'b1;
                end else if (mreq_q && cache_data_addr_ok) begin
                    mreq_d  = 1'b0;
                    mwait_d = !cache_data_data_ok;
                end else if (mwait_q && cache_data_data_ok) begin
                    mwait_d = 1'b0;
                end
                if (mem_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == S_RF) begin
                        data_we    = 1'b1;
                        data_way   = victim_q;
                        data_idx   = {index_save_q, cnt_q};
                        data_be    = 4'b1111;
                        data_wdata = cache_data_rdata;
                    end
                    if (cnt_q == LAST_WORD) begin
                        cnt_d = '0;
                        if (state_q == S_WB) begin
                            state_d = S_RF;
                        end else begin
                            state_d                         = S_IDLE;
                            tag_we                          = 1'b1;
                            valid_d[victim_q][index_save_q] = 1'b1;
                            dirty_d[victim_q][index_save_q] = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mreq_q       <= 1'b0;
            mwait_q      <= 1'b0;
            tag_save_q   <= '0;
            index_save_q <= '0;
            victim_q     <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mreq_q       <= mreq_d;
            mwait_q      <= mwait_d;
            tag_save_q   <= tag_save_d;
            index_save_q <= index_save_d;
            victim_q     <= victim_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            lru_q        <= lru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && tag_we) begin
            tag_mem[victim_q][index_save_q] <= tag_save_q;
        end
        if (!rst && data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be[b]) begin
                    data_mem[data_way][data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    assign cpu_data_addr_ok = ack && !rst;
    assign cpu_data_data_ok = ack && !rst;
    assign cpu_data_rdata   = data_mem[hit_way][{req_index, req_word}];

    assign cache_data_req   = mreq_q;
    assign cache_data_wr    = (state_q == S_WB);
    assign cache_data_size  = 2'b10;
    assign cache_data_addr  = {(state_q == S_WB) ? tag_mem[victim_q][index_save_q] : tag_save_q,
                               index_save_q, cnt_q, 2'b00};
    assign cache_data_wdata = data_mem[victim_q][{index_save_q, cnt_q}];
endmodule
`default_nettype wire

// File: tb/tb_d_cache_wb_assoc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_d_cache_wb_assoc: scoreboard bench with a random-latency memory model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_d_cache_wb_assoc;
    logic        clk, rst;
    logic        cpu_req, cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_data_rdata;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        cache_data_req, cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr, cache_data_wdata;
    logic [31:0] mem_rdata;
    logic        mem_aok, mem_dok;

    d_cache_wb_assoc #(.INDEX_WIDTH(7), .OFFSET_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_data_req(cpu_req), .cpu_data_wr(cpu_wr), .cpu_data_size(cpu_size),
        .cpu_data_addr(cpu_addr), .cpu_data_wdata(cpu_wdata),
        .cpu_data_rdata(cpu_data_rdata), .cpu_data_addr_ok(cpu_data_addr_ok),
        .cpu_data_data_ok(cpu_data_data_ok),
        .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
        .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
        .cache_data_wdata(cache_data_wdata), .cache_data_rdata(mem_rdata),
        .cache_data_addr_ok(mem_aok), .cache_data_data_ok(mem_dok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int trans_cnt = 0;

    typedef struct { bit chk; logic [31:0] rdata; } sb_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; bit chk_wd; } mtx_t;
    sb_t  sbq[$];
    mtx_t mq[$];
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hA5A5_0011 ^ (a >> 2);
    endfunction

    task automatic push_reads(input logic [31:0] base);
        for (int k = 0; k < 4; k++) mq.push_back('{1'b0, base + 32'(4*k), 32'h0, 1'b0});
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] wd);
        mq.push_back('{1'b1, a, wd, 1'b1});
    endtask

    // Memory slave: random 0..5 cycle addr_ok and data_ok delays.
    int r_da, r_dd;
    bit r_gone, r_bad;
    logic [31:0] r_a, r_wd;
    logic r_w;
    initial begin
        mem_aok = 1'b0; mem_dok = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_aok = 1'b0; mem_dok = 1'b0;
            if (cache_data_req && !rst) begin
                r_da = $urandom_range(0, 5);
                r_dd = $urandom_range(0, 5);
                r_gone = 1'b0;
                for (int i = 0; i < r_da && !r_gone; i++) begin
                    @(negedge clk);
                    if (!cache_data_req) r_gone = 1'b1;
                end
                if (!r_gone) begin
                    r_a = cache_data_addr; r_w = cache_data_wr; r_wd = cache_data_wdata;
                    if (mq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL mem_unexpected actual=%h required=none", r_a);
                    end else begin
                        mtx_t m;
                        m = mq.pop_front();
                        chk("mem_wr", {31'h0, r_w}, {31'h0, m.wr});
                        chk("mem_addr", r_a, m.addr);
                        if (m.chk_wd) chk("mem_wdata", r_wd, m.wdata);
                    end
                    chk("mem_size", {30'h0, cache_data_size}, 32'h2);
                    mem_aok = 1'b1;
                    if (r_dd == 0) begin
                        mem_dok = 1'b1;
                        mem_rdata = mem_rd(r_a);
                        if (r_w) mem[r_a] = r_wd;
                        trans_cnt++;
                    end
                    @(negedge clk);
                    mem_aok = 1'b0; mem_dok = 1'b0;
                    if (r_dd != 0) begin
                        r_bad = 1'b0;
                        for (int i = 1; i < r_dd; i++) begin
                            if (cache_data_req) r_bad = 1'b1;
                            @(negedge clk);
                        end
                        if (cache_data_req) r_bad = 1'b1;
                        mem_dok = 1'b1;
                        mem_rdata = mem_rd(r_a);
                        if (r_w) mem[r_a] = r_wd;
                        trans_cnt++;
                        @(negedge clk);
                        mem_dok = 1'b0;
                        chk("one_outstanding", {31'h0, r_bad}, 32'h0);
                    end
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && cpu_data_data_ok) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_underflow actual=%h required=none", cpu_data_rdata);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                if (e.chk) chk("cpu_rdata", cpu_data_rdata, e.rdata);
            end
        end
    end

    task automatic cpu_op(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp, input bit exp_hit,
                          input string name);
        int n, t0;
        sbq.push_back('{!wr, exp});
        t0 = trans_cnt;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = wr; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_data_addr_ok) break;
            n++;
            if (n > 1000) begin
                checks++; failures++;
                $display("FAIL %s_timeout actual=%0d required=ack", name, n);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        if (exp_hit) begin
            chk({name, "_lat"}, 32'(n), 32'h0);
            chk({name, "_traffic"}, 32'(trans_cnt - t0), 32'h0);
        end else begin
            chk({name, "_miss"}, {31'h0, n > 0}, 32'h1);
        end
    endtask

    bit idle_bad;
    int wcnt, tb0;
    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd2;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'h0, cache_data_req}, 32'h0);
        chk("rst_addr_ok", {31'h0, cpu_data_addr_ok}, 32'h0);
        chk("rst_data_ok", {31'h0, cpu_data_data_ok}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        push_reads(32'h40);
        cpu_op(0, 2, 32'h40, 0, 32'hA5A5_0001, 0, "lw40_cold");
        cpu_op(0, 2, 32'h40, 0, 32'hA5A5_0001, 1, "lw40_hit");
        cpu_op(1, 0, 32'h41, 32'h0000_EF00, 0, 1, "sb41");
        cpu_op(0, 2, 32'h40, 0, 32'hA5A5_EF01, 1, "lw40_merged");

        push_reads(32'h840);
        cpu_op(0, 2, 32'h840, 0, 32'hA5A5_0201, 0, "lwB");
        push_write(32'h40, 32'hA5A5_EF01); push_write(32'h44, 32'hA5A5_0000);
        push_write(32'h48, 32'hA5A5_0003); push_write(32'h4C, 32'hA5A5_0002);
        push_reads(32'h1040);
        cpu_op(0, 2, 32'h1040, 0, 32'hA5A5_0401, 0, "lwC_evictA");
        cpu_op(0, 2, 32'h844, 0, 32'hA5A5_0200, 1, "lwB_resident");
        cpu_op(1, 1, 32'h1042, 32'hBEEF_0000, 0, 1, "sh1042");
        cpu_op(0, 2, 32'h1040, 0, 32'hBEEF_0401, 1, "lwC_half");

        push_reads(32'h80);
        cpu_op(1, 2, 32'h84, 32'hDEAD_BEEF, 0, 0, "sw84_miss");
        cpu_op(0, 2, 32'h84, 0, 32'hDEAD_BEEF, 1, "lw84_hit");
        push_reads(32'h880);
        cpu_op(0, 2, 32'h880, 0, 32'hA5A5_0231, 0, "lw880");
        push_write(32'h80, 32'hA5A5_0031); push_write(32'h84, 32'hDEAD_BEEF);
        push_write(32'h88, 32'hA5A5_0033); push_write(32'h8C, 32'hA5A5_0032);
        push_reads(32'h1080);
        cpu_op(0, 2, 32'h1080, 0, 32'hA5A5_0431, 0, "lw1080_evict");

        // Reset while the second refill word is in progress.
        push_reads(32'hC0);
        tb0 = trans_cnt;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'hC0;
        wcnt = 0;
        while (trans_cnt == tb0 && wcnt < 200) begin @(negedge clk); wcnt++; end
        chk("rst_test_first_word", {31'h0, trans_cnt != tb0}, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rf_req", {31'h0, cache_data_req}, 32'h0);
        idle_bad = 1'b0;
        repeat (15) begin @(negedge clk); if (cache_data_req) idle_bad = 1'b1; end
        chk("rst_mid_rf_quiet", {31'h0, idle_bad}, 32'h0);
        mq.delete();

        push_reads(32'hC0);
        cpu_op(0, 2, 32'hC0, 0, 32'hA5A5_0021, 0, "lwC0_after_rst");
        push_reads(32'h840);
        cpu_op(0, 2, 32'h844, 0, 32'hA5A5_0200, 0, "lwB_after_rst");

        repeat (5) @(posedge clk);
        chk("mem_queue_empty", 32'(mq.size()), 32'h0);
        chk("sb_queue_empty", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
